// File: rtl/game_status_ctrl.sv
// Game status controller: tracks the play state, remaining lives, a saturating
// 4-digit BCD score and the post-hit invulnerability window with ship blinking.
module game_status_ctrl #(
    parameter int ASTEROID_COUNT = 10,
    parameter int LIVES          = 3,
    parameter int INVULN_FRAMES  = 120
) (
    input  logic                      clk_pix,
    input  logic                      rst,
    input  logic                      frame,
    input  logic                      start,
    input  logic                      collision,
    input  logic [ASTEROID_COUNT-1:0] asteroid_shot,
    output logic [1:0]                state,
    output logic [1:0]                lives,
    output logic [15:0]               score_bcd,
    output logic                      invuln,
    output logic                      ship_visible
);
    localparam int NW = $clog2(ASTEROID_COUNT + 1);
    localparam logic [1:0] LIVES_INIT  = 2'(LIVES);
    localparam logic [7:0] INVULN_INIT = 8'(INVULN_FRAMES);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAYING   = 2'd1,
        HIT       = 2'd2,
        GAME_OVER = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  lives_reg, lives_next;
    logic [15:0] score_reg, score_next;
    logic [7:0]  counter_reg, counter_next;
    logic        invuln_reg, invuln_next;
    logic        visible_reg, visible_next;
    logic        frame_d_reg;
    logic        start_d_reg;
    logic        armed_reg;

    logic        start_edge;
    logic        sample;
    logic [NW-1:0] shot_count;
    logic [15:0] shot_ext;
    logic [3:0]  n_digit [4];
    logic [4:0]  carry;
    logic [15:0] add_sum;
    logic [15:0] score_added;

    // armed_reg blocks an edge from a button already held when reset releases
    assign start_edge = start & ~start_d_reg & armed_reg;
    assign sample     = frame_d_reg;

    always_comb begin
        shot_count = '0;
        for (int i = 0; i < ASTEROID_COUNT; i++) begin
            shot_count = shot_count + NW'(asteroid_shot[i]);
        end
    end

    assign shot_ext = 16'(shot_count);
    assign carry[0] = 1'b0;

    // Decimal digits of the hit count, then a ripple BCD add on the score
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
            logic [4:0] raw;
            assign n_digit[gi] = 4'((shot_ext / 16'(10 ** gi)) % 16'd10);
            assign raw = {1'b0, score_reg[4*gi +: 4]} + {1'b0, n_digit[gi]} + {4'b0, carry[gi]};
            assign carry[gi+1] = (raw > 5'd9);
            assign add_sum[4*gi +: 4] = carry[gi+1] ? 4'(raw - 5'd10) : raw[3:0];
        end
    endgenerate

    assign score_added = carry[4] ? 16'h9999 : add_sum;

    always_comb begin
        state_next   = state_reg;
        lives_next   = lives_reg;
        score_next   = score_reg;
        counter_next = counter_reg;
        case (state_reg)
            IDLE: begin
                if (start_edge) begin
                    state_next = PLAYING;
                    score_next = '0;
                    lives_next = LIVES_INIT;
                end
            end
            PLAYING: begin
                if (sample) begin
                    score_next = score_added;
                    if (collision) begin
                        if (lives_reg > 2'd1) begin
                            lives_next   = lives_reg - 2'd1;
                            state_next   = HIT;
                            counter_next = INVULN_INIT;
                        end else begin
                            lives_next = '0;
                            state_next = GAME_OVER;
                        end
                    end
                end
            end
            HIT: begin
                if (sample) begin
                    score_next   = score_added;
                    counter_next = counter_reg - 8'd1;
                    if (counter_reg == 8'd1) begin
                        state_next = PLAYING;
                    end
                end
            end
            GAME_OVER: begin
                if (start_edge) begin
                    state_next = IDLE;
                    lives_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase

        invuln_next  = (state_next == HIT);
        visible_next = 1'b0;
        if (state_next == PLAYING) begin
            visible_next = 1'b1;
        end else if (state_next == HIT) begin
            visible_next = counter_next[3];
        end
    end

    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            lives_reg   <= '0;
            score_reg   <= '0;
            counter_reg <= '0;
            invuln_reg  <= 1'b0;
            visible_reg <= 1'b0;
            frame_d_reg <= 1'b0;
            start_d_reg <= 1'b0;
            armed_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            lives_reg   <= lives_next;
            score_reg   <= score_next;
            counter_reg <= counter_next;
            invuln_reg  <= invuln_next;
            visible_reg <= visible_next;
            frame_d_reg <= frame;
            start_d_reg <= start;
            armed_reg   <= armed_reg | ~start;
        end
    end

    assign state        = state_reg;
    assign lives        = lives_reg;
    assign score_bcd    = score_reg;
    assign invuln       = invuln_reg;
    assign ship_visible = visible_reg;

endmodule

// File: tb/tb_game_status_ctrl.sv
// Scoreboard bench for game_status_ctrl: a behavioural game model pushes the
// expected outputs per transaction and they are popped against the DUT.
module tb_game_status_ctrl;
    localparam int AC = 10;

    logic          clk_pix = 1'b0;
    logic          rst = 1'b0;
    logic          frame = 1'b0;
    logic          start = 1'b0;
    logic          collision = 1'b0;
    logic [AC-1:0] asteroid_shot = '0;
    logic [1:0]    state;
    logic [1:0]    lives;
    logic [15:0]   score_bcd;
    logic          invuln;
    logic          ship_visible;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       tag;
        logic [1:0]  st;
        logic [1:0]  lv;
        logic [15:0] sc;
        logic        inv;
        logic        vis;
    } exp_t;
    exp_t sb[$];

    // Reference model of the game
    int m_state = 0;
    int m_lives = 0;
    int m_score = 0;
    int m_cnt   = 0;

    game_status_ctrl #(.ASTEROID_COUNT(AC), .LIVES(3), .INVULN_FRAMES(120)) dut (
        .clk_pix      (clk_pix),
        .rst          (rst),
        .frame        (frame),
        .start        (start),
        .collision    (collision),
        .asteroid_shot(asteroid_shot),
        .state        (state),
        .lives        (lives),
        .score_bcd    (score_bcd),
        .invuln       (invuln),
        .ship_visible (ship_visible)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return 16'(((v / 1000) % 10) << 12 | ((v / 100) % 10) << 8 | ((v / 10) % 10) << 4 | (v % 10));
    endfunction

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.st  = 2'(m_state);
        e.lv  = 2'(m_lives);
        e.sc  = to_bcd(m_score);
        e.inv = (m_state == 2);
        e.vis = (m_state == 1) ? 1'b1 : (m_state == 2) ? 1'((m_cnt >> 3) & 1) : 1'b0;
        sb.push_back(e);
    endtask

    task automatic pop_compare();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check({e.tag, ".state"}, 32'(state), 32'(e.st));
        check({e.tag, ".lives"}, 32'(lives), 32'(e.lv));
        check({e.tag, ".score"}, 32'(score_bcd), 32'(e.sc));
        check({e.tag, ".invuln"}, 32'(invuln), 32'(e.inv));
        check({e.tag, ".visible"}, 32'(ship_visible), 32'(e.vis));
        $display("[TB] txn %s: state=%0d lives=%0d score=%h invuln=%0d vis=%0d",
                 e.tag, state, lives, score_bcd, invuln, ship_visible);
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    task automatic model_reset();
        m_state = 0;
        m_lives = 0;
        m_score = 0;
        m_cnt   = 0;
    endtask

    // Asynchronous reset pulse placed mid-cycle; outputs checked before any clock edge
    task automatic reset_pulse(input string tag);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        push_exp(tag);
        pop_compare();
        tick();
        #2;
        rst = 1'b0;
        tick();
    endtask

    task automatic press_start(input string tag);
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
        tick();
        if (m_state == 0) begin
            m_state = 1;
            m_lives = 3;
            m_score = 0;
        end else if (m_state == 3) begin
            m_state = 0;
            m_lives = 0;
        end
        push_exp(tag);
        pop_compare();
    endtask

    task automatic do_frame(input string tag, input logic col, input logic [AC-1:0] shots);
        collision     = col;
        asteroid_shot = shots;
        frame         = 1'b1;
        tick();
        frame = 1'b0;
        tick();
        collision     = 1'b0;
        asteroid_shot = '0;
        if (m_state == 1 || m_state == 2) begin
            m_score = m_score + $countones(shots);
            if (m_score > 9999) m_score = 9999;
        end
        if (m_state == 1 && col) begin
            if (m_lives > 1) begin
                m_lives = m_lives - 1;
                m_state = 2;
                m_cnt   = 120;
            end else begin
                m_lives = 0;
                m_state = 3;
            end
        end else if (m_state == 2) begin
            if (m_cnt == 1) m_state = 1;
            m_cnt = m_cnt - 1;
        end
        push_exp(tag);
        tick();
        pop_compare();
    endtask

    initial begin
        logic [AC-1:0] v;
        int k;

        // Power-on reset
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        push_exp("por");
        pop_compare();
        tick();
        tick();
        #2;
        rst = 1'b0;
        tick();
        tick();

        press_start("start");
        do_frame("shots3", 1'b0, 10'b0000010011);
        press_start("start_ignored_playing");
        do_frame("no_shots", 1'b0, 10'b0);

        // Count up through BCD carries from zero
        reset_pulse("rst_a");
        press_start("start_a");
        for (int i = 0; i < 33; i++) do_frame("three", 1'b0, 10'b0000000111);
        do_frame("carry_0102", 1'b0, 10'b0000000111);

        // Drive the score to 9995, then saturate
        while (m_score < 9995) begin
            k = (9995 - m_score > 10) ? 10 : 9995 - m_score;
            v = AC'((1 << k) - 1);
            do_frame("climb", 1'b0, v);
        end
        do_frame("sat", 1'b0, '1);
        do_frame("sat_hold", 1'b0, '1);

        // Hit with collision held high through the invulnerability window
        reset_pulse("rst_b");
        press_start("start_b");
        do_frame("hit1", 1'b1, '0);
        for (int i = 0; i < 120; i++) do_frame("hit_hold", 1'b1, '0);
        do_frame("hit2", 1'b1, '0);
        for (int i = 0; i < 120; i++) do_frame("hit2_wait", 1'b0, 10'b0000000001);
        do_frame("last_life", 1'b1, 10'b0100000001);
        do_frame("over_frozen", 1'b0, 10'b0000000011);
        press_start("to_idle");
        press_start("restart");

        // Reset during HIT with start held across release
        do_frame("hit3", 1'b1, '0);
        start = 1'b1;
        tick();
        tick();
        push_exp("start_ignored_hit");
        pop_compare();
        reset_pulse("rst_c");
        for (int i = 0; i < 4; i++) tick();
        do_frame("held_start", 1'b0, 10'b0000000011);
        start = 1'b0;
        tick();
        tick();
        push_exp("start_released");
        pop_compare();
        press_start("fresh_start");

        if (sb.size() != 0) check("scoreboard_leftover", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
